// File: rtl/screen_clear_sweeper.sv
// screen_clear_sweeper: sits in front of vga_adapter. In normal operation it
// forwards the cursor pixel write with one register stage. On a rising edge of
// the synchronised clear request it owns the pixel bus and paints every pixel
// CLEAR_COLOUR in raster order, then emits a one-cycle done pulse.
// Optional feature macro: CLEAR_RECENTRE_EN (drives recentre/centre_x/centre_y
// in the done cycle; tied to 0 when undefined).
module screen_clear_sweeper #(
  parameter int               H_RES        = 160,
  parameter int               V_RES        = 120,
  parameter int               X_W          = 8,
  parameter int               Y_W          = 7,
  parameter int               COL_W        = 3,
  parameter logic [COL_W-1:0] CLEAR_COLOUR = '0
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             clear_req,
  input  logic [X_W-1:0]   cur_x,
  input  logic [Y_W-1:0]   cur_y,
  input  logic [COL_W-1:0] cur_colour,
  input  logic             cur_plot,
  output logic [X_W-1:0]   x_out,
  output logic [Y_W-1:0]   y_out,
  output logic [COL_W-1:0] colour_out,
  output logic             plot_out,
  output logic             busy,
  output logic             done,
  output logic             recentre,
  output logic [X_W-1:0]   centre_x,
  output logic [Y_W-1:0]   centre_y
);

  localparam logic [X_W-1:0] X_LAST = X_W'(H_RES - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_RES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               sync1_q, sync1_d;
  logic               sync2_q, sync2_d;
  logic               req_prev_q, req_prev_d;
  logic [X_W-1:0]     xc_q, xc_d;
  logic [Y_W-1:0]     yc_q, yc_d;
  logic [X_W-1:0]     x_q, x_d;
  logic [Y_W-1:0]     y_q, y_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic               plot_q, plot_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               trigger;

  // Request synchroniser and rising-edge detector; the edge history always
  // tracks req_s so a request seen during a sweep is consumed, not queued.
  always_comb begin
    sync1_d    = clear_req;
    sync2_d    = sync1_q;
    req_prev_d = sync2_q;
    trigger    = sync2_q & ~req_prev_q;
  end

  // Next-state and look-ahead output decode: output registers are loaded with
  // the values belonging to the next state, so they line up with state_q and
  // xc_q/yc_q always name the pixel currently on the bus during a sweep.
  always_comb begin
    state_d = state_q;
    xc_d    = xc_q;
    yc_d    = yc_q;
    x_d     = cur_x;
    y_d     = cur_y;
    col_d   = cur_colour;
    plot_d  = cur_plot;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (trigger) begin
          state_d = SWEEP;
          xc_d    = '0;
          yc_d    = '0;
          x_d     = '0;
          y_d     = '0;
          col_d   = CLEAR_COLOUR;
          plot_d  = 1'b1;
          busy_d  = 1'b1;
        end
      end
      SWEEP: begin
        x_d    = '0;
        y_d    = '0;
        col_d  = CLEAR_COLOUR;
        busy_d = 1'b1;
        if (xc_q == X_LAST && yc_q == Y_LAST) begin
          state_d = DONE;
          xc_d    = '0;
          yc_d    = '0;
          plot_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          if (xc_q == X_LAST) begin
            xc_d = '0;
            yc_d = yc_q + Y_W'(1);
          end else begin
            xc_d = xc_q + X_W'(1);
          end
          x_d    = xc_d;
          y_d    = yc_d;
          plot_d = 1'b1;
        end
      end
      DONE: begin
        // Leaving DONE: the defaults already forward cur_* sampled now.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, synchroniser, counter and output registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      req_prev_q <= 1'b0;
      xc_q       <= '0;
      yc_q       <= '0;
      x_q        <= '0;
      y_q        <= '0;
      col_q      <= '0;
      plot_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      req_prev_q <= req_prev_d;
      xc_q       <= xc_d;
      yc_q       <= yc_d;
      x_q        <= x_d;
      y_q        <= y_d;
      col_q      <= col_d;
      plot_q     <= plot_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign x_out      = x_q;
  assign y_out      = y_q;
  assign colour_out = col_q;
  assign plot_out   = plot_q;
  assign busy       = busy_q;
  assign done       = done_q;

`ifdef CLEAR_RECENTRE_EN
  localparam logic [X_W-1:0] CENTRE_X = X_W'(H_RES / 2);
  localparam logic [Y_W-1:0] CENTRE_Y = Y_W'(V_RES / 2);

  logic           recentre_q, recentre_d;
  logic [X_W-1:0] centre_x_q, centre_x_d;
  logic [Y_W-1:0] centre_y_q, centre_y_d;

  // DONE lasts one cycle, so entering it gives a single-cycle recentre pulse;
  // the centre coordinates stick until reset.
  always_comb begin
    recentre_d = (state_d == DONE);
    centre_x_d = centre_x_q;
    centre_y_d = centre_y_q;
    if (state_d == DONE) begin
      centre_x_d = CENTRE_X;
      centre_y_d = CENTRE_Y;
    end
  end

  // Recentre output registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      recentre_q <= 1'b0;
      centre_x_q <= '0;
      centre_y_q <= '0;
    end else begin
      recentre_q <= recentre_d;
      centre_x_q <= centre_x_d;
      centre_y_q <= centre_y_d;
    end
  end

  assign recentre = recentre_q;
  assign centre_x = centre_x_q;
  assign centre_y = centre_y_q;
`else
  assign recentre = 1'b0;
  assign centre_x = '0;
  assign centre_y = '0;
`endif

endmodule

// File: tb/tb_screen_clear_sweeper.sv
// Directed bench for screen_clear_sweeper: passthrough, full sweep ordering,
// ignored mid-sweep requests, held request, mid-sweep reset and recentre.
module tb_screen_clear_sweeper;

`ifdef CLEAR_RECENTRE_EN
  localparam int REC_EN = 1;
`else
  localparam int REC_EN = 0;
`endif
  localparam int NPIX = 160 * 120;

  logic       clock = 1'b0;
  logic       resetn;
  logic       clear_req;
  logic [7:0] cur_x;
  logic [6:0] cur_y;
  logic [2:0] cur_colour;
  logic       cur_plot;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour_out;
  logic       plot_out, busy, done, recentre;
  logic [7:0] centre_x;
  logic [6:0] centre_y;

  int vectors     = 0;
  int miscompares = 0;

  // Monitor state (written only by the monitor process).
  logic mon_clr = 1'b0;
  int   plot_cnt, done_cnt, order_err, rec_err;
  int   exp_x, exp_y;

  screen_clear_sweeper dut (
    .clock(clock), .resetn(resetn), .clear_req(clear_req),
    .cur_x(cur_x), .cur_y(cur_y), .cur_colour(cur_colour), .cur_plot(cur_plot),
    .x_out(x_out), .y_out(y_out), .colour_out(colour_out), .plot_out(plot_out),
    .busy(busy), .done(done), .recentre(recentre),
    .centre_x(centre_x), .centre_y(centre_y)
  );

  always #5 clock = ~clock;

  // Sweep monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clock) begin
    if (mon_clr || !resetn) begin
      if (mon_clr) begin
        plot_cnt  = 0;
        done_cnt  = 0;
        order_err = 0;
        rec_err   = 0;
      end
      exp_x = 0;
      exp_y = 0;
    end else begin
      if (busy && plot_out) begin
        plot_cnt++;
        if (int'(x_out) != exp_x || int'(y_out) != exp_y || colour_out != 3'b000)
          order_err++;
        exp_x++;
        if (exp_x == 160) begin
          exp_x = 0;
          exp_y++;
        end
      end
      if (busy && !plot_out && !done) order_err++;
      if (done) begin
        done_cnt++;
        exp_x = 0;
        exp_y = 0;
      end
      if (recentre && (!done || REC_EN == 0)) rec_err++;
      if (REC_EN == 0 && (centre_x != 0 || centre_y != 0)) rec_err++;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic clear_monitor();
    mon_clr = 1'b1;
    tick();
    mon_clr = 1'b0;
  endtask

  task automatic wait_busy(output int n);
    n = 0;
    while (!busy && n < 10) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_done(output logic ok);
    int n;
    n = 0;
    while (!done && n < 25000) begin
      tick();
      n++;
    end
    ok = done;
  endtask

  initial begin
    int   n;
    logic ok;
    resetn     = 1'b0;
    clear_req  = 1'b0;
    cur_x      = 8'd0;
    cur_y      = 7'd0;
    cur_colour = 3'd0;
    cur_plot   = 1'b0;
    clear_monitor();
    tick();

    // T1: reset state and passthrough
    check("rst_x", x_out, 0);
    check("rst_plot", plot_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_recentre", {recentre, centre_x, centre_y}, 0);
    resetn     = 1'b1;
    cur_x      = 8'd6;
    cur_y      = 7'd7;
    cur_colour = 3'b101;
    cur_plot   = 1'b1;
    tick();
    check("t1_x", x_out, 6);
    check("t1_y", y_out, 7);
    check("t1_colour", colour_out, 5);
    check("t1_plot", plot_out, 1);
    check("t1_busy", busy, 0);

    // T2: full sweep
    clear_req = 1'b1;
    wait_busy(n);
    check("t2_busy_latency", (n >= 2 && n <= 3), 1);
    check("t2_first_pixel", {x_out, y_out, colour_out, plot_out}, {8'd0, 7'd0, 3'd0, 1'b1});
    wait_done(ok);
    check("t2_done_seen", ok, 1);
    check("t2_plot_count", plot_cnt, NPIX);
    check("t2_order", order_err, 0);
    check("t2_done_plot", plot_out, 0);
    check("t2_done_busy", busy, 1);
    check("t6_recentre", recentre, REC_EN);
    check("t6_centre_x", centre_x, REC_EN ? 80 : 0);
    check("t6_centre_y", centre_y, REC_EN ? 60 : 0);
    cur_x      = 8'd33;
    cur_y      = 7'd44;
    cur_colour = 3'd3;
    tick();
    check("t2_done_width", done, 0);
    check("t2_busy_low", busy, 0);
    check("t2_pass_after_done", {x_out, y_out, colour_out, plot_out}, {8'd33, 7'd44, 3'd3, 1'b1});
    check("t6_centre_hold", centre_x, REC_EN ? 80 : 0);
    check("t2_done_count", done_cnt, 1);

    // T3: request toggled mid-sweep is ignored
    clear_req = 1'b0;
    cur_plot  = 1'b0;
    repeat (4) tick();
    clear_monitor();
    clear_req = 1'b1;
    wait_busy(n);
    check("t3_busy", busy, 1);
    n = 0;
    while (plot_cnt < 5000 && n < 6000) begin
      tick();
      n++;
    end
    clear_req = 1'b0;
    repeat (4) tick();
    clear_req = 1'b1;
    wait_done(ok);
    check("t3_done_seen", ok, 1);
    repeat (10) tick();
    check("t3_plot_count", plot_cnt, NPIX);
    check("t3_done_count", done_cnt, 1);
    check("t3_order", order_err, 0);
    check("t3_idle", busy, 0);

    // T4: request held high for 30000 cycles
    clear_req = 1'b0;
    repeat (5) tick();
    clear_monitor();
    clear_req = 1'b1;
    repeat (30000) tick();
    check("t4_plot_count", plot_cnt, NPIX);
    check("t4_done_count", done_cnt, 1);
    check("t4_order", order_err, 0);

    // T5: reset at pixel 100
    clear_req = 1'b0;
    repeat (5) tick();
    clear_monitor();
    clear_req = 1'b1;
    n = 0;
    while (plot_cnt < 100 && n < 200) begin
      tick();
      n++;
    end
    check("t5_reached_100", plot_cnt, 100);
    #2 resetn = 1'b0;
    #1;
    check("t5_async_outputs", {x_out, y_out, colour_out, plot_out, busy, done}, 0);
    check("t5_async_recentre", {recentre, centre_x, centre_y}, 0);
    clear_req = 1'b0;
    tick();
    #2 resetn = 1'b1;
    cur_x      = 8'd12;
    cur_y      = 7'd34;
    cur_colour = 3'd6;
    cur_plot   = 1'b1;
    tick();
    tick();
    check("t5_pass_resumes", {x_out, y_out, colour_out, plot_out}, {8'd12, 7'd34, 3'd6, 1'b1});
    check("t5_not_busy", busy, 0);
    check("t6_recentre_rules", rec_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
